// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: fetch/decode/execute/memory/writeback sequencer for a multicycle RV64I datapath
module multicycle_control_unit #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic                 zero,
  input  logic                 lt,
  input  logic                 mem_ready,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 pc_src,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 iord,
  output logic                 alu_src,
  output logic [1:0]           alu_op,
  output logic                 reg_write,
  output logic                 mem_to_reg,
  output logic                 illegal_instr,
  output logic [CNT_WIDTH-1:0] instr_retired
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;
  state_t state, next_state;
  logic retire, is_r, is_i, is_ld, is_st, is_br, legal, taken;
  assign is_r  = opcode == 7'b0110011;
  assign is_i  = opcode == 7'b0010011;
  assign is_ld = opcode == 7'b0000011;
  assign is_st = opcode == 7'b0100011;
  assign is_br = opcode == 7'b1100011;
  assign legal = is_r | is_i | is_ld | is_st | is_br;
  assign taken = (funct3 == 3'b000 & zero) | (funct3 == 3'b001 & ~zero) |
                 (funct3 == 3'b100 & lt)   | (funct3 == 3'b101 & ~lt);
  // State register and retired-instruction counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= FETCH;
      instr_retired <= '0;
    end else begin
      state <= next_state;
      if (retire) instr_retired <= instr_retired + 1'b1;
    end
  end
  // Next-state and control decode from state plus IR fields and flags
  always_comb begin
    next_state    = state;
    retire        = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_src        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    iord          = 1'b0;
    alu_src       = 1'b0;
    alu_op        = 2'b00;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    illegal_instr = 1'b0;
    case (state)
      FETCH: begin
        mem_read   = 1'b1;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        next_state = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        illegal_instr = ~legal;
        next_state    = legal ? EXEC : FETCH;
      end
      EXEC: begin
        alu_src    = is_i | is_ld | is_st;
        alu_op     = (is_r | is_i) ? 2'b10 : is_br ? 2'b01 : 2'b00;
        pc_write   = is_br & taken;
        pc_src     = is_br & taken;
        retire     = is_br;
        next_state = (is_ld | is_st) ? MEM : (is_r | is_i) ? WB : FETCH;
      end
      MEM: begin
        iord       = 1'b1;
        alu_src    = 1'b1;
        mem_read   = is_ld;
        mem_write  = is_st;
        retire     = mem_ready & is_st;
        next_state = ~mem_ready ? MEM : is_ld ? WB : FETCH;
      end
      WB: begin
        reg_write  = 1'b1;
        mem_to_reg = is_ld;
        alu_src    = is_i | is_ld;
        alu_op     = (is_r | is_i) ? 2'b10 : 2'b00;
        retire     = 1'b1;
        next_state = FETCH;
      end
      default: next_state = FETCH;
    endcase
  end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: randomized and directed check of the multicycle sequencer against a per-instruction trace model
module tb_multicycle_control_unit;
  logic clk = 1'b0, reset = 1'b1, zero = 1'b0, lt = 1'b0, mem_ready = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic ir_write, pc_write, pc_src, mem_read, mem_write, iord, alu_src, reg_write, mem_to_reg, illegal_instr;
  logic [1:0] alu_op;
  logic [3:0] instr_retired, cnt = '0;
  logic [11:0] outs;
  int tests = 0, fails = 0;

  multicycle_control_unit #(.CNT_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .zero(zero), .lt(lt),
    .mem_ready(mem_ready), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .alu_src(alu_src),
    .alu_op(alu_op), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .illegal_instr(illegal_instr), .instr_retired(instr_retired)
  );

  always #5 clk = ~clk;
  assign outs = {ir_write, pc_write, pc_src, mem_read, mem_write, iord, alu_src, alu_op, reg_write, mem_to_reg, illegal_instr};

  function automatic logic [11:0] mk(input logic irw, pcw, pcs, mr, mw, io, as, input logic [1:0] op, input logic rw, m2r, ill);
    return {irw, pcw, pcs, mr, mw, io, as, op, rw, m2r, ill};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Builds the expected per-cycle control trace of one instruction, then drives and checks it.
  // abort >= 0 asserts reset during that cycle index and abandons the instruction.
  task automatic run(input logic [6:0] op, input logic [2:0] f3, input logic z, input logic l,
                     input int fs, input int ms, input int abort);
    logic [11:0] ev[$];
    logic rq[$];
    logic rr, ii, ld, st, br, legal, tk, as;
    logic [1:0] aop;
    rr = op == 7'b0110011; ii = op == 7'b0010011; ld = op == 7'b0000011;
    st = op == 7'b0100011; br = op == 7'b1100011;
    legal = rr | ii | ld | st | br;
    for (int i = 0; i < fs; i++) begin ev.push_back(mk(0,0,0,1,0,0,0,2'b00,0,0,0)); rq.push_back(1'b0); end
    ev.push_back(mk(1,1,0,1,0,0,0,2'b00,0,0,0)); rq.push_back(1'b1);
    ev.push_back(mk(0,0,0,0,0,0,0,2'b00,0,0,!legal)); rq.push_back(1'($urandom_range(1)));
    if (legal) begin
      case (f3)
        3'b000: tk = z;
        3'b001: tk = !z;
        3'b100: tk = l;
        3'b101: tk = !l;
        default: tk = 1'b0;
      endcase
      tk = tk & br;
      as = ii | ld | st;
      aop = (rr | ii) ? 2'b10 : br ? 2'b01 : 2'b00;
      ev.push_back(mk(0,tk,tk,0,0,0,as,aop,0,0,0)); rq.push_back(1'($urandom_range(1)));
      if (ld | st) begin
        for (int i = 0; i <= ms; i++) begin ev.push_back(mk(0,0,0,ld,st,1,1,2'b00,0,0,0)); rq.push_back(i == ms); end
      end
      if (rr | ii | ld) begin ev.push_back(mk(0,0,0,0,0,0,as,aop,1,ld,0)); rq.push_back(1'($urandom_range(1))); end
    end
    opcode = op; funct3 = f3; zero = z; lt = l;
    for (int k = 0; k < ev.size(); k++) begin
      mem_ready = rq[k];
      reset = (k == abort);
      @(negedge clk);
      chk($sformatf("ctl op=%b cyc=%0d", op, k), 32'(outs), 32'(ev[k]));
      @(posedge clk); #1;
      if (k == abort) begin reset = 1'b0; cnt = '0; break; end
    end
    if (legal && abort < 0) cnt = cnt + 1'b1;
    chk("retired", 32'(instr_retired), 32'(cnt));
  endtask

  task automatic check_fetch_idle(input string tag);
    mem_ready = 1'b0;
    @(negedge clk);
    chk(tag, 32'(outs), 32'(mk(0,0,0,1,0,0,0,2'b00,0,0,0)));
    chk({tag, "_cnt"}, 32'(instr_retired), 32'(cnt));
    @(posedge clk); #1;
  endtask

  initial begin
    logic [6:0] ops [5];
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011};
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check_fetch_idle("reset_fetch");
    run(7'b0110011, 3'b000, 0, 0, 0, 0, -1);
    run(7'b0000011, 3'b010, 0, 0, 2, 3, -1);
    run(7'b0100011, 3'b010, 0, 0, 0, 2, -1);
    run(7'b1100011, 3'b000, 1, 0, 0, 0, -1);
    run(7'b1100011, 3'b000, 0, 0, 0, 0, -1);
    run(7'b1111111, 3'b000, 0, 0, 0, 0, -1);
    run(7'b0100011, 3'b011, 0, 0, 1, 2, 4);
    check_fetch_idle("abort_fetch");
    for (int i = 0; i < 16; i++) run(7'b1100011, 3'(i), i[0], i[1], 0, 0, -1);
    chk("wrap", 32'(instr_retired), 32'(0));
    for (int n = 0; n < 60; n++) begin
      logic [6:0] op;
      op = ($urandom_range(4) == 0) ? 7'($urandom) : ops[$urandom_range(4)];
      run(op, 3'($urandom), 1'($urandom), 1'($urandom), $urandom_range(2), $urandom_range(3), -1);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
